// File: rtl/gamma_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gamma_lut_ctrl
// Purpose  : Configuration controller for the double-banked R/G/B gamma LUT
//            RAMs. Host writes go to the shadow bank. A commit is held
//            pending until the next frame start, and then the read bank and
//            the gamma enable flag swap together. A frame therefore always
//            uses a single curve.
// Ports    : clk, rst            - pixel clock, async active-high reset
//            i_vsync             - frame sync (active level = VSYNC_POL)
//            cfg_wr_*            - host table write (valid/ready handshake)
//            cfg_commit          - shadow table complete, swap at next frame
//            cfg_enable          - gamma enable applied at the swap
//            lut_we/waddr/wdata  - shadow-bank write port, 1-cycle latency
//            lut_rd_bank         - bank the datapath reads
//            gamma_en            - datapath enable (0 = pass-through)
//            commit_pending      - commit accepted, swap not yet done
//            swap_done           - one-cycle pulse while the swap takes effect
//            swap_cnt            - swaps performed, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module gamma_lut_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vsync,
    input  logic          cfg_wr_valid,
    output logic          cfg_wr_ready,
    input  logic [1:0]    cfg_wr_chan,
    input  logic [AW-1:0] cfg_wr_addr,
    input  logic [DW-1:0] cfg_wr_data,
    input  logic          cfg_commit,
    input  logic          cfg_enable,
    output logic [2:0]    lut_we,
    output logic [AW:0]   lut_waddr,
    output logic [DW-1:0] lut_wdata,
    output logic          lut_rd_bank,
    output logic          gamma_en,
    output logic          commit_pending,
    output logic          swap_done,
    output logic [7:0]    swap_cnt
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PEND = 2'd1;
    localparam logic [1:0] c_ST_SWAP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_vs_act_d;
    logic          w_vs_act;
    logic          w_fs;
    logic          w_wr_acc;
    logic          w_commit_acc;
    logic          w_do_swap;
    logic [2:0]    w_we_dec;
    logic          r_en_latched;
    logic [2:0]    r_lut_we;
    logic [AW:0]   r_lut_waddr;
    logic [DW-1:0] r_lut_wdata;
    logic          r_rd_bank;
    logic          r_gamma_en;
    logic [7:0]    r_swap_cnt;

    // Frame start is the leading edge of the active vsync level, so a vsync
    // held active for many cycles produces a single frame start.
    assign w_vs_act = (i_vsync == VSYNC_POL);
    assign w_fs     = w_vs_act & ~r_vs_act_d;

    // Writes are only taken while the shadow bank is open (IDLE). Once a
    // commit is pending the shadow content is frozen until the swap.
    assign w_wr_acc     = cfg_wr_valid & cfg_wr_ready;
    assign w_commit_acc = cfg_commit & (r_state == c_ST_IDLE);
    // The swap needs PEND to be held already. A commit that coincides with a
    // frame start only reaches PEND afterwards and waits for the next frame.
    assign w_do_swap    = (r_state == c_ST_PEND) & w_fs;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_commit_acc) w_state_nxt = c_ST_PEND;
            c_ST_PEND: if (w_fs)         w_state_nxt = c_ST_SWAP;
            c_ST_SWAP:                   w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_we_dec = 3'b000;
        case (cfg_wr_chan)
            2'd0:    w_we_dec = 3'b001;
            2'd1:    w_we_dec = 3'b010;
            2'd2:    w_we_dec = 3'b100;
            default: w_we_dec = 3'b111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_vs_act_d   <= 1'b0;
            r_en_latched <= 1'b0;
            r_lut_we     <= 3'b000;
            r_lut_waddr  <= '0;
            r_lut_wdata  <= '0;
            r_rd_bank    <= 1'b0;
            r_gamma_en   <= 1'b0;
            r_swap_cnt   <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs_act_d <= w_vs_act;
            r_lut_we   <= w_wr_acc ? w_we_dec : 3'b000;
            if (w_wr_acc) begin
                // The shadow bank is always the one the datapath is not reading.
                r_lut_waddr <= {~r_rd_bank, cfg_wr_addr};
                r_lut_wdata <= cfg_wr_data;
            end
            if (w_commit_acc) begin
                r_en_latched <= cfg_enable;
            end
            // The bank, enable and count update on entry to SWAP, so all three
            // are visible in the same cycle that swap_done pulses.
            if (w_do_swap) begin
                r_rd_bank  <= ~r_rd_bank;
                r_gamma_en <= r_en_latched;
                r_swap_cnt <= r_swap_cnt + 8'd1;
            end
        end
    end

    assign cfg_wr_ready   = (r_state == c_ST_IDLE);
    assign commit_pending = (r_state == c_ST_PEND);
    assign swap_done      = (r_state == c_ST_SWAP);
    assign lut_we         = r_lut_we;
    assign lut_waddr      = r_lut_waddr;
    assign lut_wdata      = r_lut_wdata;
    assign lut_rd_bank    = r_rd_bank;
    assign gamma_en       = r_gamma_en;
    assign swap_cnt       = r_swap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gamma_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamma_lut_ctrl
// Purpose  : Self-checking bench for gamma_lut_ctrl. A high-active and a
//            low-active instance run side by side; the low-active one sees
//            the inverted vsync, so both must behave identically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamma_lut_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vsync;
    logic          vsync_n;
    logic          cfg_wr_valid;
    logic [1:0]    cfg_wr_chan;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          cfg_commit;
    logic          cfg_enable;

    logic          cfg_wr_ready, lut_rd_bank, gamma_en, commit_pending, swap_done;
    logic [2:0]    lut_we;
    logic [AW:0]   lut_waddr;
    logic [DW-1:0] lut_wdata;
    logic [7:0]    swap_cnt;

    logic          n_ready, n_bank, n_en, n_pend, n_done;
    logic [2:0]    n_we;
    logic [AW:0]   n_waddr;
    logic [DW-1:0] n_wdata;
    logic [7:0]    n_cnt;

    assign vsync_n = ~i_vsync;

    always #5 clk = ~clk;

    gamma_lut_ctrl #(.DW(DW), .AW(AW), .VSYNC_POL(1'b1)) dut (
        .clk(clk), .rst(rst), .i_vsync(i_vsync),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_chan(cfg_wr_chan), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_enable(cfg_enable),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .lut_rd_bank(lut_rd_bank), .gamma_en(gamma_en),
        .commit_pending(commit_pending), .swap_done(swap_done), .swap_cnt(swap_cnt)
    );

    gamma_lut_ctrl #(.DW(DW), .AW(AW), .VSYNC_POL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .i_vsync(vsync_n),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(n_ready),
        .cfg_wr_chan(cfg_wr_chan), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_enable(cfg_enable),
        .lut_we(n_we), .lut_waddr(n_waddr), .lut_wdata(n_wdata),
        .lut_rd_bank(n_bank), .gamma_en(n_en),
        .commit_pending(n_pend), .swap_done(n_done), .swap_cnt(n_cnt)
    );

    typedef struct {
        logic [1:0]    chan;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    we;
        logic [AW:0]   waddr;
    } vec_t;

    typedef struct {
        logic [2:0]    we;
        logic [AW:0]   waddr;
        logic [DW-1:0] wdata;
    } exp_t;

    vec_t vecs[4];
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    // Reference model of the controller as seen from its ports.
    int         m_st;      // 0 idle, 1 pending, 2 swap
    logic       m_bank, m_en, m_en_l, m_vs_d;
    logic [7:0] m_cnt;

    function automatic logic [2:0] dec(input logic [1:0] c);
        case (c)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_bank = 1'b0;
        m_en   = 1'b0;
        m_en_l = 1'b0;
        m_vs_d = 1'b0;
        m_cnt  = 8'd0;
        sbq.delete();
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_we"},     32'(lut_we), 32'(0));
        chk({tag, "_waddr"},  32'(lut_waddr), 32'(0));
        chk({tag, "_wdata"},  32'(lut_wdata), 32'(0));
        chk({tag, "_bank"},   32'(lut_rd_bank), 32'(0));
        chk({tag, "_en"},     32'(gamma_en), 32'(0));
        chk({tag, "_pend"},   32'(commit_pending), 32'(0));
        chk({tag, "_done"},   32'(swap_done), 32'(0));
        chk({tag, "_cnt"},    32'(swap_cnt), 32'(0));
        chk({tag, "_n_we"},   32'(n_we), 32'(0));
        chk({tag, "_n_bank"}, 32'(n_bank), 32'(0));
        chk({tag, "_n_cnt"},  32'(n_cnt), 32'(0));
    endtask

    // One clock: check handshake and push expected writes before the edge,
    // then step the model and compare every output 1 ns after the edge.
    task automatic cyc();
        logic fs;
        logic got;
        exp_t e;
        chk("ready", 32'(cfg_wr_ready), 32'(m_st == 0));
        chk("n_ready", 32'(n_ready), 32'(m_st == 0));
        if (cfg_wr_valid && m_st == 0) begin
            e.we    = dec(cfg_wr_chan);
            e.waddr = {~m_bank, cfg_wr_addr};
            e.wdata = cfg_wr_data;
            sbq.push_back(e);
        end
        fs = i_vsync && !m_vs_d;
        case (m_st)
            0: if (cfg_commit) begin m_st = 1; m_en_l = cfg_enable; end
            1: if (fs) begin m_st = 2; m_bank = ~m_bank; m_en = m_en_l; m_cnt = m_cnt + 8'd1; end
            default: m_st = 0;
        endcase
        m_vs_d = i_vsync;
        @(posedge clk);
        #1;
        got = (sbq.size() > 0);
        e.we = 3'b000;
        if (got) e = sbq.pop_front();
        chk("lut_we", 32'(lut_we), 32'(e.we));
        chk("n_lut_we", 32'(n_we), 32'(e.we));
        if (got) begin
            chk("lut_waddr", 32'(lut_waddr), 32'(e.waddr));
            chk("lut_wdata", 32'(lut_wdata), 32'(e.wdata));
            chk("n_lut_waddr", 32'(n_waddr), 32'(e.waddr));
            chk("n_lut_wdata", 32'(n_wdata), 32'(e.wdata));
        end
        chk("pending", 32'(commit_pending), 32'(m_st == 1));
        chk("swap_done", 32'(swap_done), 32'(m_st == 2));
        chk("rd_bank", 32'(lut_rd_bank), 32'(m_bank));
        chk("gamma_en", 32'(gamma_en), 32'(m_en));
        chk("swap_cnt", 32'(swap_cnt), 32'(m_cnt));
        chk("n_pending", 32'(n_pend), 32'(m_st == 1));
        chk("n_swap_done", 32'(n_done), 32'(m_st == 2));
        chk("n_rd_bank", 32'(n_bank), 32'(m_bank));
        chk("n_gamma_en", 32'(n_en), 32'(m_en));
        chk("n_swap_cnt", 32'(n_cnt), 32'(m_cnt));
    endtask

    task automatic commit(input logic en);
        cfg_commit = 1'b1;
        cfg_enable = en;
        cyc();
        cfg_commit = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd1, 8'h10, 8'hA5, 3'b010, 9'h110};
        vecs[1] = '{2'd3, 8'h22, 8'h5A, 3'b111, 9'h122};
        vecs[2] = '{2'd0, 8'hFF, 8'h01, 3'b001, 9'h1FF};
        vecs[3] = '{2'd2, 8'h00, 8'hFE, 3'b100, 9'h100};

        rst = 1'b1; i_vsync = 1'b0; cfg_wr_valid = 1'b0; cfg_wr_chan = 2'd0;
        cfg_wr_addr = '0; cfg_wr_data = '0; cfg_commit = 1'b0; cfg_enable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_vals("rst0");
        rst = 1'b0;
        chk("rst0_ready", 32'(cfg_wr_ready), 32'(1));

        // Single writes from the vector table, back to back.
        for (int i = 0; i < 4; i++) begin
            cfg_wr_valid = 1'b1;
            cfg_wr_chan  = vecs[i].chan;
            cfg_wr_addr  = vecs[i].addr;
            cfg_wr_data  = vecs[i].data;
            cyc();
            chk("tbl_we", 32'(lut_we), 32'(vecs[i].we));
            chk("tbl_waddr", 32'(lut_waddr), 32'(vecs[i].waddr));
            chk("tbl_wdata", 32'(lut_wdata), 32'(vecs[i].data));
        end
        cfg_wr_valid = 1'b0;
        cyc();

        // Full table load, commit, then a frame start 10 cycles later.
        for (int a = 0; a < 256; a++) begin
            cfg_wr_valid = 1'b1;
            cfg_wr_chan  = 2'd3;
            cfg_wr_addr  = AW'(a);
            cfg_wr_data  = DW'(a) ^ 8'h3C;
            cyc();
        end
        cfg_wr_valid = 1'b0;
        commit(1'b1);
        chk("load_pend", 32'(commit_pending), 32'(1));
        repeat (10) cyc();
        chk("load_pend10", 32'(commit_pending), 32'(1));
        i_vsync = 1'b1;
        cyc();
        chk("load_bank", 32'(lut_rd_bank), 32'(1));
        chk("load_en", 32'(gamma_en), 32'(1));
        chk("load_done", 32'(swap_done), 32'(1));
        chk("load_cnt", 32'(swap_cnt), 32'(1));
        cyc();
        chk("load_done_pulse", 32'(swap_done), 32'(0));
        i_vsync = 1'b0;
        cyc();
        cfg_wr_valid = 1'b1; cfg_wr_chan = 2'd0; cfg_wr_addr = 8'h05; cfg_wr_data = 8'h33;
        cyc();
        chk("post_swap_waddr", 32'(lut_waddr), 32'(9'h005));
        cfg_wr_valid = 1'b0;

        // Backpressure while a commit is pending.
        commit(1'b0);
        cfg_wr_valid = 1'b1; cfg_wr_chan = 2'd2; cfg_wr_addr = 8'h77; cfg_wr_data = 8'hC3;
        repeat (5) cyc();
        chk("bp_ready", 32'(cfg_wr_ready), 32'(0));
        i_vsync = 1'b1;
        cyc();
        chk("bp_swap_we", 32'(lut_we), 32'(0));
        chk("bp_swap_bank", 32'(lut_rd_bank), 32'(0));
        chk("bp_swap_en", 32'(gamma_en), 32'(0));
        cyc();
        chk("bp_idle_we", 32'(lut_we), 32'(0));
        cyc();
        chk("bp_we", 32'(lut_we), 32'(3'b100));
        chk("bp_waddr", 32'(lut_waddr), 32'(9'h177));
        cfg_wr_valid = 1'b0;
        i_vsync = 1'b0;
        cyc();

        // Commit coincident with the frame start, then long vsync pulses.
        i_vsync = 1'b1;
        commit(1'b1);
        chk("coin_pend", 32'(commit_pending), 32'(1));
        chk("coin_cnt", 32'(swap_cnt), 32'(2));
        repeat (99) cyc();
        chk("coin_hold_cnt", 32'(swap_cnt), 32'(2));
        i_vsync = 1'b0;
        cyc();
        i_vsync = 1'b1;
        cyc();
        chk("coin_swap_cnt", 32'(swap_cnt), 32'(3));
        chk("coin_swap_bank", 32'(lut_rd_bank), 32'(1));
        repeat (99) cyc();
        chk("long_vs_cnt", 32'(swap_cnt), 32'(3));
        i_vsync = 1'b0;
        cyc();

        // Write and commit together, then reset mid-pending.
        cfg_wr_valid = 1'b1; cfg_wr_chan = 2'd3; cfg_wr_addr = 8'h42; cfg_wr_data = 8'h99;
        commit(1'b0);
        chk("wc_we", 32'(lut_we), 32'(3'b111));
        chk("wc_waddr", 32'(lut_waddr), 32'(9'h042));
        chk("wc_pend", 32'(commit_pending), 32'(1));
        cfg_wr_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        reset_vals("async");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("async_ready", 32'(cfg_wr_ready), 32'(1));
        i_vsync = 1'b1;
        cyc();
        chk("nopend_cnt", 32'(swap_cnt), 32'(0));
        chk("nopend_bank", 32'(lut_rd_bank), 32'(0));
        i_vsync = 1'b0;
        cyc();

        // 256 commit/frame cycles: counter wraps, bank returns to 0.
        for (int i = 0; i < 256; i++) begin
            commit(1'b1);
            i_vsync = 1'b1;
            cyc();
            i_vsync = 1'b0;
            cyc();
            if (i == 254) chk("wrap_cnt255", 32'(swap_cnt), 32'(255));
        end
        chk("wrap_cnt", 32'(swap_cnt), 32'(0));
        chk("wrap_bank", 32'(lut_rd_bank), 32'(0));
        chk("wrap_n_cnt", 32'(n_cnt), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
